// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forward-select codes,
// controller states and the scoreboard entry layout.
package pipe_pkg;

  typedef enum logic [2:0] {
    FWD_RF  = 3'd0,
    FWD_EXM = 3'd1,
    FWD_WBA = 3'd2,
    FWD_WBM = 3'd3
  } fwd_e;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rwd;
    logic       ld;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select match of one source register against the EX and MEM
// scoreboard entries; the nearest producer wins and $0 never forwards.
module hazard_fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  sb_entry_t  ex,
  input  sb_entry_t  mem,
  output fwd_e       sel
);

  always_comb begin
    sel = FWD_RF;
    if (src != '0) begin
      if (ex.v && (ex.rwd == src)) begin
        sel = FWD_EXM;
      end else if (mem.v && (mem.rwd == src)) begin
        sel = mem.ld ? FWD_WBM : FWD_WBA;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller beside ID: scoreboard of in-flight destinations,
// registered forward selects, load-use stall and taken-branch flush.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int BR_FLUSH = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rwd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             br_taken,
  output logic [2:0]       rs_fwd,
  output logic [2:0]       rt_fwd,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The branch cycle itself is the first flush cycle, so the down-counter
  // holds the cycles still owed after the current one.
  localparam logic [1:0]       FLUSH_RELOAD = 2'(BR_FLUSH - 1);
  localparam state_e           FLUSH_NEXT   = (BR_FLUSH > 1) ? S_FLUSH : S_RUN;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       fcnt_q, fcnt_d;
  sb_entry_t        ex_q, ex_d, mem_q, mem_d;
  fwd_e             rs_fwd_q, rs_fwd_d, rt_fwd_q, rt_fwd_d;
  fwd_e             rs_sel, rt_sel;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             load_use, stall, flush, bubble;

  hazard_fwd_sel u_rs_sel (
    .src (id_rs),
    .ex  (ex_q),
    .mem (mem_q),
    .sel (rs_sel)
  );

  hazard_fwd_sel u_rt_sel (
    .src (id_rt),
    .ex  (ex_q),
    .mem (mem_q),
    .sel (rt_sel)
  );

  always_comb begin
    load_use = id_valid && ex_q.v && ex_q.ld &&
               (((ex_q.rwd == id_rs) && (id_rs != '0)) ||
                ((ex_q.rwd == id_rt) && (id_rt != '0)));
  end

  // Stall and flush are Mealy outputs so the hazard cycle itself holds ID;
  // S_STALL marks the single re-evaluation cycle that follows.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_RUN, S_STALL: begin
          if (br_taken) begin
            flush   = 1'b1;
            state_d = FLUSH_NEXT;
            fcnt_d  = FLUSH_RELOAD;
          end else if (load_use) begin
            stall   = 1'b1;
            state_d = S_STALL;
          end else begin
            state_d = S_RUN;
          end
        end
        S_FLUSH: begin
          flush = 1'b1;
          if (br_taken) begin
            state_d = FLUSH_NEXT;
            fcnt_d  = FLUSH_RELOAD;
          end else if (fcnt_q <= 2'd1) begin
            state_d = S_RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end
        default: begin
          state_d = S_RUN;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    bubble = stall || flush;

    mem_d  = ex_q;
    ex_d.v   = id_valid && id_wr_en && (id_rwd != '0) && !bubble;
    ex_d.rwd = id_rwd;
    ex_d.ld  = id_is_load;

    rs_fwd_d = bubble ? FWD_RF : rs_sel;
    rt_fwd_d = bubble ? FWD_RF : rt_sel;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      fcnt_q      <= '0;
      ex_q        <= SB_EMPTY;
      mem_q       <= SB_EMPTY;
      rs_fwd_q    <= FWD_RF;
      rt_fwd_q    <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      rs_fwd_q    <= rs_fwd_d;
      rt_fwd_q    <= rt_fwd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign rs_fwd    = rs_fwd_q;
  assign rt_fwd    = rt_fwd_q;
  assign stall_if  = stall;
  assign stall_id  = stall;
  assign bubble_ex = bubble;
  assign flush_id  = flush;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
